// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the MEM stage.
// Define MEM_ARBITER_TIMEOUT_EN to enable the wait-state watchdog and err flag.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              stall_req,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    IF_WAIT,
    ACK
  } state_t;

  state_t            state, state_n;
  logic              ram_re_n, ram_we_n;
  logic [ADDR_W-1:0] ram_addr_n;
  logic [3:0]        ram_sel_n;
  logic [DATA_W-1:0] ram_wdata_n;
  logic [DATA_W-1:0] if_rdata_n, mem_rdata_n;
  logic              if_ack_n, mem_ack_n, err_n;
  logic              waiting, timeout;

  assign waiting = (state == MEM_WAIT) || (state == IF_WAIT);

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wdog, wdog_n;

  assign timeout = waiting && !ram_ready &&
                   (wdog == CW'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero in IDLE, so it is clear on every WAIT entry
  always_comb begin
    wdog_n = wdog;
    if (state == IDLE)
      wdog_n = '0;
    else if (waiting && !ram_ready && !timeout)
      wdog_n = wdog + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) wdog <= '0;
    else     wdog <= wdog_n;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    ram_re_n    = ram_re;
    ram_we_n    = ram_we;
    ram_addr_n  = ram_addr;
    ram_sel_n   = ram_sel;
    ram_wdata_n = ram_wdata;
    if_rdata_n  = if_rdata;
    mem_rdata_n = mem_rdata;
    if_ack_n    = 1'b0;
    mem_ack_n   = 1'b0;
    err_n       = err;
    unique case (state)
      IDLE: begin
        ram_re_n = 1'b0;
        ram_we_n = 1'b0;
        // MEM wins: it carries the older instruction
        if (mem_re || mem_we) begin
          ram_addr_n  = mem_addr;
          ram_sel_n   = mem_sel;
          ram_wdata_n = mem_wdata;
          ram_we_n    = mem_we;
          ram_re_n    = ~mem_we;
          state_n     = MEM_WAIT;
        end else if (if_req) begin
          ram_addr_n = if_addr;
          ram_sel_n  = 4'b1111;
          ram_re_n   = 1'b1;
          state_n    = IF_WAIT;
        end
      end
      MEM_WAIT, IF_WAIT: begin
        if (ram_ready || timeout) begin
          ram_re_n = 1'b0;
          ram_we_n = 1'b0;
          state_n  = ACK;
          err_n    = err | ~ram_ready;
          if (state == MEM_WAIT) begin
            mem_ack_n = 1'b1;
            if (!ram_ready)
              mem_rdata_n = '0;
            else if (ram_re)
              mem_rdata_n = ram_rdata;
          end else begin
            if_ack_n   = 1'b1;
            if_rdata_n = ram_ready ? ram_rdata : '0;
          end
        end
      end
      ACK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_sel   <= 4'b0000;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      ram_re    <= ram_re_n;
      ram_we    <= ram_we_n;
      ram_addr  <= ram_addr_n;
      ram_sel   <= ram_sel_n;
      ram_wdata <= ram_wdata_n;
      if_rdata  <= if_rdata_n;
      mem_rdata <= mem_rdata_n;
      if_ack    <= if_ack_n;
      mem_ack   <= mem_ack_n;
      err       <= err_n;
    end
  end

  assign stall_req = ((mem_re | mem_we) & ~mem_ack) | (if_req & ~if_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a
// randomized run against a RAM responder and a memory scoreboard.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        ram_re, ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;
  logic        stall_req;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  int          ram_lat = 1;
  bit          ram_rand = 1'b0;
  bit          poke = 1'b0;
  int          rcnt;
  logic [31:0] exp_mem_rd = '0;
  logic [31:0] exp_if_rd = '0;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ack(if_ack),
    .mem_re(mem_re),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_sel(mem_sel),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .ram_re(ram_re),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_sel(ram_sel),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .ram_ready(ram_ready),
    .stall_req(stall_req),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [3:0] s,
                                        logic [31:0] w);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ram_rd(logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // RAM responder: ready arrives ram_lat cycles after the enables rise
  initial begin
    ram_ready = 1'b0;
    ram_rdata = '0;
    rcnt = 0;
    forever begin
      @(negedge clk);
      ram_ready = poke;
      if (ram_re || ram_we) begin
        rcnt++;
        if (rcnt == ram_lat + 1) begin
          ram_ready = 1'b1;
          if (ram_we) begin
            ram_mem[ram_addr] = merge(ram_rd(ram_addr), ram_sel, ram_wdata);
            ram_rdata = $urandom;
          end else begin
            ram_rdata = ram_rd(ram_addr);
          end
        end
      end else begin
        rcnt = 0;
        if (ram_rand) ram_lat = int'($urandom_range(1, 4));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({ram_re, ram_we, if_ack, mem_ack, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {ram_re, ram_we, if_ack, mem_ack, err});
    end
    checks++;
    if (ram_addr !== 32'h0 || ram_sel !== 4'h0 || ram_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_ram: got %h/%h/%h want zeros",
               ram_addr, ram_sel, ram_wdata);
    end
    checks++;
    if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want zeros", if_rdata, mem_rdata);
    end
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b want 0", stall_req);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    ram_lat = 2;
    ram_mem[32'h100] = 32'h24020005;
    if_req = 1'b1;
    if_addr = 32'h100;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (ram_re !== (k < 3) || ram_we !== 1'b0) begin
        errors++;
        $display("FAIL fetch_en k=%0d: got re=%b we=%b want re=%b",
                 k, ram_re, ram_we, k < 3);
      end
      checks++;
      if (if_ack !== (k == 3) || mem_ack !== 1'b0) begin
        errors++;
        $display("FAIL fetch_ack k=%0d: got %b want %b", k, if_ack, k == 3);
      end
      checks++;
      if (stall_req !== (k < 3)) begin
        errors++;
        $display("FAIL fetch_stall k=%0d: got %b want %b", k, stall_req, k < 3);
      end
      if (k < 3) begin
        checks++;
        if (ram_addr !== 32'h100 || ram_sel !== 4'hF) begin
          errors++;
          $display("FAIL fetch_hold k=%0d: got %h/%h want 100/f",
                   k, ram_addr, ram_sel);
        end
      end
      if (k == 3) begin
        exp_if_rd = 32'h24020005;
        checks++;
        if (if_rdata !== exp_if_rd) begin
          errors++;
          $display("FAIL fetch_data: got %h want %h", if_rdata, exp_if_rd);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_conflict();
    logic [31:0] ea;
    ram_lat = 1;
    mem_re = 1'b1;
    mem_addr = 32'h200;
    mem_sel = 4'hF;
    if_req = 1'b1;
    if_addr = 32'h104;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (ram_re !== (k inside {0, 1, 4, 5})) begin
        errors++;
        $display("FAIL conflict_re k=%0d: got %b", k, ram_re);
      end
      checks++;
      if (mem_ack !== (k == 2) || if_ack !== (k == 6)) begin
        errors++;
        $display("FAIL conflict_ack k=%0d: got mem=%b if=%b", k, mem_ack, if_ack);
      end
      if (k inside {0, 1, 4, 5}) begin
        ea = (k < 2) ? 32'h200 : 32'h104;
        checks++;
        if (ram_addr !== ea) begin
          errors++;
          $display("FAIL conflict_addr k=%0d: got %h want %h", k, ram_addr, ea);
        end
      end
      if (k == 2) begin
        exp_mem_rd = init_word(32'h200);
        checks++;
        if (mem_rdata !== exp_mem_rd) begin
          errors++;
          $display("FAIL conflict_mdata: got %h want %h", mem_rdata, exp_mem_rd);
        end
        mem_re = 1'b0;
      end
      if (k == 6) begin
        exp_if_rd = init_word(32'h104);
        checks++;
        if (if_rdata !== exp_if_rd) begin
          errors++;
          $display("FAIL conflict_idata: got %h want %h", if_rdata, exp_if_rd);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_store();
    logic [31:0] ew;
    ram_lat = 2;
    mem_we = 1'b1;
    mem_addr = 32'h300;
    mem_sel = 4'b0011;
    mem_wdata = 32'hDEADBEEF;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (ram_we !== (k < 3) || ram_re !== 1'b0) begin
        errors++;
        $display("FAIL store_en k=%0d: got we=%b re=%b", k, ram_we, ram_re);
      end
      checks++;
      if (mem_ack !== (k == 3)) begin
        errors++;
        $display("FAIL store_ack k=%0d: got %b want %b", k, mem_ack, k == 3);
      end
      if (k < 3) begin
        checks++;
        if (ram_addr !== 32'h300 || ram_sel !== 4'b0011 ||
            ram_wdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL store_hold k=%0d: got %h/%h/%h", k,
                   ram_addr, ram_sel, ram_wdata);
        end
      end
      if (k == 3) begin
        checks++;
        if (mem_rdata !== exp_mem_rd) begin
          errors++;
          $display("FAIL store_rdata: got %h want %h", mem_rdata, exp_mem_rd);
        end
      end
      if (k == 4) mem_we = 1'b0;
    end
    ew = merge(init_word(32'h300), 4'b0011, 32'hDEADBEEF);
    checks++;
    if (ram_rd(32'h300) !== ew) begin
      errors++;
      $display("FAIL store_ram: got %h want %h", ram_rd(32'h300), ew);
    end
  endtask

  task automatic test_held();
    int issues = 0;
    logic pen = 1'b0;
    ram_lat = 1;
    mem_re = 1'b1;
    mem_addr = 32'h208;
    mem_sel = 4'hF;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ram_re && !pen) issues++;
      pen = ram_re;
      checks++;
      if (mem_ack !== (k == 2)) begin
        errors++;
        $display("FAIL held_ack k=%0d: got %b want %b", k, mem_ack, k == 2);
      end
      if (k == 2) exp_mem_rd = init_word(32'h208);
      if (k == 3) mem_re = 1'b0;
    end
    checks++;
    if (issues != 1) begin
      errors++;
      $display("FAIL held_issues: got %0d want 1", issues);
    end
  endtask

  task automatic test_reset_mid();
    ram_lat = 10;
    if_req = 1'b1;
    if_addr = 32'h108;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (if_ack !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_ack k=%0d: got %b want 0", k, if_ack);
      end
      checks++;
      if (ram_re !== (k < 2) || ram_we !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_en k=%0d: got %b want %b", k, ram_re, k < 2);
      end
      if (k == 1) rst = 1'b1;
      if (k == 2) begin
        rst = 1'b0;
        if_req = 1'b0;
      end
      if (k == 3) poke = 1'b1;
      if (k == 4) poke = 1'b0;
    end
    exp_mem_rd = '0;
    exp_if_rd = '0;
    checks++;
    if (if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_rdata: got %h want 0", if_rdata);
    end
  endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    ram_lat = 1000;
    mem_re = 1'b1;
    mem_addr = 32'h500;
    for (int k = 0; k < 11; k++) begin
      tick();
      checks++;
      if (ram_re !== (k < 8) || mem_ack !== (k == 8)) begin
        errors++;
        $display("FAIL tmo_seq k=%0d: got re=%b ack=%b", k, ram_re, mem_ack);
      end
      checks++;
      if (err !== (k >= 8)) begin
        errors++;
        $display("FAIL tmo_err k=%0d: got %b want %b", k, err, k >= 8);
      end
      if (k == 8) begin
        checks++;
        if (mem_rdata !== 32'h0) begin
          errors++;
          $display("FAIL tmo_rdata: got %h want 0", mem_rdata);
        end
        mem_re = 1'b0;
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_mem_rd = '0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear: got %b want 0", err);
    end
  endtask
`endif

  task automatic test_random();
    bit ma = 0, ia = 0, mst = 0, mboth = 0;
    logic [31:0] ma_a = '0, ma_w = '0, ia_a = '0;
    logic [3:0] ms = '0;
    int owner = 0, mw = 0, iw = 0;
    bit pen = 0, pm = 0, pi = 0, me, ie;
    logic [69:0] held = '0;
    ram_rand = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      tick();
      me = ram_ready && owner == 1;
      ie = ram_ready && owner == 2;
      checks++;
      if (mem_ack !== me || if_ack !== ie) begin
        errors++;
        $display("FAIL rnd_ack c=%0d: got mem=%b if=%b want %b %b",
                 c, mem_ack, if_ack, me, ie);
      end
      if (me) begin
        if (mst) ref_mem[ma_a] = merge(ref_rd(ma_a), ms, ma_w);
        else exp_mem_rd = ref_rd(ma_a);
        checks++;
        if (mem_rdata !== exp_mem_rd) begin
          errors++;
          $display("FAIL rnd_mdata c=%0d: got %h want %h", c, mem_rdata, exp_mem_rd);
        end
        ma = 0;
        owner = 0;
      end
      if (ie) begin
        exp_if_rd = ref_rd(ia_a);
        checks++;
        if (if_rdata !== exp_if_rd) begin
          errors++;
          $display("FAIL rnd_idata c=%0d: got %h want %h", c, if_rdata, exp_if_rd);
        end
        ia = 0;
        owner = 0;
      end
      if ((ram_re || ram_we) && !pen) begin
        checks++;
        if (pm) begin
          owner = 1;
          if (ram_we !== mst || ram_re !== !mst || ram_addr !== ma_a ||
              ram_sel !== ms || ram_wdata !== ma_w) begin
            errors++;
            $display("FAIL rnd_mem_issue c=%0d: got %b%b %h %h %h want %b %h",
                     c, ram_re, ram_we, ram_addr, ram_sel, ram_wdata, mst, ma_a);
          end
        end else if (pi) begin
          owner = 2;
          if (ram_re !== 1'b1 || ram_we !== 1'b0 || ram_addr !== ia_a ||
              ram_sel !== 4'hF) begin
            errors++;
            $display("FAIL rnd_if_issue c=%0d: got %b%b %h %h want %h",
                     c, ram_re, ram_we, ram_addr, ram_sel, ia_a);
          end
        end else begin
          errors++;
          $display("FAIL rnd_spurious c=%0d: got issue with no request", c);
        end
        held = {ram_re, ram_we, ram_addr, ram_sel, ram_wdata};
      end else if (ram_re || ram_we) begin
        checks++;
        if ({ram_re, ram_we, ram_addr, ram_sel, ram_wdata} !== held) begin
          errors++;
          $display("FAIL rnd_hold c=%0d: got %h want %h", c,
                   {ram_re, ram_we, ram_addr, ram_sel, ram_wdata}, held);
        end
      end
      pen = ram_re || ram_we;
      if (!ma && $urandom_range(0, 2) == 0) begin
        ma = 1;
        mw = 0;
        mst = 1'($urandom_range(0, 1));
        mboth = 1'($urandom_range(0, 1));
        ma_a = 32'h400 + 32'($urandom_range(0, 15)) * 4;
        ms = 4'($urandom);
        ma_w = $urandom;
      end
      if (!ia && $urandom_range(0, 2) == 0) begin
        ia = 1;
        iw = 0;
        ia_a = 32'h400 + 32'($urandom_range(0, 15)) * 4;
      end
      mem_we = ma && mst;
      mem_re = ma && (!mst || mboth);
      mem_addr = ma_a;
      mem_sel = ms;
      mem_wdata = ma_w;
      if_req = ia;
      if_addr = ia_a;
      pm = ma;
      pi = ia;
      if (ma) mw++;
      if (ia) iw++;
      #1;
      checks++;
      if (stall_req !== ((ma && !me) || (ia && !ie))) begin
        errors++;
        $display("FAIL rnd_stall c=%0d: got %b", c, stall_req);
      end
      if (mw > 150 || iw > 150) begin
        checks++;
        errors++;
        $display("FAIL rnd_hang c=%0d: got waits %0d/%0d want <=150", c, mw, iw);
        break;
      end
    end
    ram_rand = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
    if_req = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rnd_err: got %b want 0", err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    mem_re = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_sel = '0;
    mem_wdata = '0;
    test_reset();
    test_fetch();
    test_conflict();
    test_store();
    test_held();
    test_reset_mid();
`ifdef MEM_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port RAM arbiter and sequencer between instruction fetch (IF) and the data-memory stage (MEM, driven from the EX/MEM register outputs).
- Issues one RAM transaction at a time and holds RAM controls stable until the RAM reports ready.
- Returns read data with a one-cycle ack pulse to the winning requester.
- Drives a stall request to the pipeline controller while any request is outstanding.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  IF read request; held until if_ack.
- if_addr  in  ADDR_W  IF fetch address.
- if_rdata  out  DATA_W  fetched word; valid when if_ack=1.
- if_ack  out  1  one-cycle IF completion pulse.
- mem_re  in  1  MEM load request.
- mem_we  in  1  MEM store request.
- mem_addr  in  ADDR_W  MEM address.
- mem_sel  in  4  byte lane select.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load word; valid when mem_ack=1.
- mem_ack  out  1  one-cycle MEM completion pulse.
- ram_re  out  1  RAM read enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_sel  out  4  RAM byte select.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; sampled when ram_ready=1.
- ram_ready  in  1  RAM completion for the current transaction.
- stall_req  out  1  pipeline stall request (combinational).
- err  out  1  timeout flag; constant 0 without TIMEOUT_EN.

Behaviour:
- Reset:
  - All outputs are registered except stall_req.
  - Reset values: state=IDLE; ram_re=0; ram_we=0; ram_addr=0; ram_sel=4'b0000; ram_wdata=0; if_rdata=0; mem_rdata=0; if_ack=0; mem_ack=0; err=0; watchdog counter=0.
- States: IDLE, MEM_WAIT, IF_WAIT, ACK.
- IDLE:
  - Priority is MEM over IF, because MEM holds the older instruction.
  - If mem_re or mem_we: latch mem_addr, mem_sel and mem_wdata onto ram_*, then go to MEM_WAIT.
    - mem_we=1 gives ram_we=1, ram_re=0. If mem_re and mem_we are both high, the write wins.
    - Otherwise ram_re=1, ram_we=0.
  - Else if if_req: ram_addr=if_addr, ram_sel=4'b1111, ram_re=1, then go to IF_WAIT.
  - Else remain in IDLE with ram_re=ram_we=0.
- MEM_WAIT / IF_WAIT:
  - All ram_* outputs are held constant.
  - Requester inputs are ignored; a request dropped mid-transaction still completes and is still acked.
  - On ram_ready=1 at an edge:
    - Capture ram_rdata into mem_rdata or if_rdata (loads and fetches only; for stores mem_rdata holds its old value).
    - Deassert ram_re and ram_we.
    - Set the matching ack and go to ACK.
- ACK:
  - Exactly one cycle with the ack high.
  - All requests are ignored, so no duplicate issue occurs.
  - Next state is IDLE with acks cleared.
  - Requesters must deassert, or present a new request, in the cycle after ack.
- Latency: with ram_ready returned N cycles after issue (N≥1), the ack rises N+1 cycles after the request is first sampled in IDLE. Minimum request-to-request turnaround is 3 cycles.
- stall_req = ((mem_re|mem_we) & ~mem_ack) | (if_req & ~if_ack).
- ram_ready outside the WAIT states is ignored.
- Reset mid-transaction drops the transaction: no ack, and the RAM enables fall at the reset edge.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- Defined:
  - The watchdog counter clears on entering a WAIT state and increments each WAIT cycle without ram_ready.
  - When the count reaches TIMEOUT_CYCLES-1 with ram_ready still 0:
    - Abort the transaction and deassert the RAM enables.
    - Force the corresponding rdata to 0.
    - Enter ACK with the ack high and err=1.
  - err is sticky until rst.
  - A ram_ready arriving in the same cycle as the timeout wins, and err is not set.
- Undefined: no counter; WAIT states are unbounded; err is tied to 0.

Test Plan:
- Fetch: if_req=1, if_addr=0x100, ram_ready 2 cycles after issue with ram_rdata=0x24020005 -> ram_re=1 and ram_addr=0x100 held; if_ack pulses 1 cycle later with if_rdata=0x24020005; stall_req stays 1 until that cycle.
- Conflict: mem_re=1 (mem_addr=0x200) and if_req=1 (if_addr=0x104) in the same IDLE cycle -> MEM issued first; IF issued only after mem_ack's ACK cycle; IF never acked before MEM.
- Store: mem_we=1, mem_addr=0x300, mem_sel=4'b0011, mem_wdata=0xDEADBEEF -> ram_we=1 with those values stable through the wait; mem_ack pulses; mem_rdata unchanged.
- Held request: requester holds mem_re=1 through ACK and drops it the cycle after -> exactly one RAM read issued, no duplicate.
- Reset: assert rst during IF_WAIT -> next edge gives ram_re=0, state IDLE, if_ack never pulses; a later ram_ready is ignored.
- With MEM_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8: ram_ready never asserted -> mem_ack pulses after 8 wait cycles with mem_rdata=0 and err=1, err stays 1 until rst.
